// File: rtl/ncpu32k_exp_seq_if.sv
// Bundle of request, machine-state-register and redirect signals around the
// exception sequencer. "master" is the sequencer side, "slave" the environment.
interface ncpu32k_exp_seq_if #(
  parameter int DW     = 32,
  parameter int PSR_DW = 10
);
  logic              req_ifault;
  logic              req_dtlb;
  logic              req_syscall;
  logic              req_eret;
  logic              irq;
  logic [DW-1:0]     req_pc;
  logic [DW-1:0]     req_lsa;
  logic              exp_busy;
  logic [PSR_DW-1:0] msr_psr;
  logic              msr_psr_ire;
  logic [DW-1:0]     msr_epc;
  logic              flush_req;
  logic              flush_ack;
  logic              msr_exp_ent;
  logic              msr_psr_restore;
  logic              msr_epsr_we;
  logic [PSR_DW-1:0] msr_epsr_nxt;
  logic              msr_epc_we;
  logic [DW-1:0]     msr_epc_nxt;
  logic              msr_elsa_we;
  logic [DW-1:0]     msr_elsa_nxt;
  logic              redir_valid;
  logic [DW-1:0]     redir_pc;
  logic              redir_ready;

  modport master (
    input  req_ifault, req_dtlb, req_syscall, req_eret, irq, req_pc, req_lsa,
    input  msr_psr, msr_psr_ire, msr_epc, flush_ack, redir_ready,
    output exp_busy, flush_req, msr_exp_ent, msr_psr_restore,
    output msr_epsr_we, msr_epsr_nxt, msr_epc_we, msr_epc_nxt,
    output msr_elsa_we, msr_elsa_nxt, redir_valid, redir_pc
  );

  modport slave (
    output req_ifault, req_dtlb, req_syscall, req_eret, irq, req_pc, req_lsa,
    output msr_psr, msr_psr_ire, msr_epc, flush_ack, redir_ready,
    input  exp_busy, flush_req, msr_exp_ent, msr_psr_restore,
    input  msr_epsr_we, msr_epsr_nxt, msr_epc_we, msr_epc_nxt,
    input  msr_elsa_we, msr_elsa_nxt, redir_valid, redir_pc
  );
endinterface

// File: rtl/ncpu32k_exp_seq.sv
// Exception entry/return sequencer: IDLE -> FLUSH -> COMMIT -> REDIR.
// Optional macro NCPU_EXP_IRQ_SYNC_EN adds a 2-flop synchronizer on irq.
module ncpu32k_exp_seq #(
  parameter int          NCPU_DW      = 32,
  parameter int          NCPU_PSR_DW  = 10,
  parameter logic [31:0] VECT_IFAULT  = 32'h0000_0004,
  parameter logic [31:0] VECT_DTLB    = 32'h0000_0008,
  parameter logic [31:0] VECT_SYSCALL = 32'h0000_000C,
  parameter logic [31:0] VECT_IRQ     = 32'h0000_0010
) (
  input logic                 clk,
  input logic                 rst,
  ncpu32k_exp_seq_if.master   bus_io
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_COMMIT, S_REDIR} state_t;
  typedef enum logic [2:0] {C_IFAULT, C_DTLB, C_SYSCALL, C_ERET, C_IRQ} cause_t;

  state_t                 state_q, state_d;
  cause_t                 cause_q, cause_d;
  logic [NCPU_DW-1:0]     pc_q, lsa_q, tgt_q, tgt_d;
  logic [NCPU_PSR_DW-1:0] psr_q;
  logic                   irq_w;
  logic                   req_any;
  logic                   accept;

`ifdef NCPU_EXP_IRQ_SYNC_EN
  logic irq_s1_q, irq_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_s1_q <= 1'b0;
      irq_s2_q <= 1'b0;
    end else begin
      irq_s1_q <= bus_io.irq;
      irq_s2_q <= irq_s1_q;
    end
  end

  assign irq_w = irq_s2_q;
`else
  assign irq_w = bus_io.irq;
`endif

  // Fixed-priority arbitration; the redirect target is resolved at acceptance
  // so redir_pc stays stable even if msr_epc changes later.
  always_comb begin
    req_any = 1'b1;
    cause_d = C_IFAULT;
    tgt_d   = NCPU_DW'(VECT_IFAULT);
    if (bus_io.req_ifault) begin
      cause_d = C_IFAULT;
      tgt_d   = NCPU_DW'(VECT_IFAULT);
    end else if (bus_io.req_dtlb) begin
      cause_d = C_DTLB;
      tgt_d   = NCPU_DW'(VECT_DTLB);
    end else if (bus_io.req_syscall) begin
      cause_d = C_SYSCALL;
      tgt_d   = NCPU_DW'(VECT_SYSCALL);
    end else if (bus_io.req_eret) begin
      cause_d = C_ERET;
      tgt_d   = bus_io.msr_epc;
    end else if (irq_w && bus_io.msr_psr_ire) begin
      cause_d = C_IRQ;
      tgt_d   = NCPU_DW'(VECT_IRQ);
    end else begin
      req_any = 1'b0;
    end
  end

  assign accept = (state_q == S_IDLE) && req_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_q <= C_IFAULT;
      pc_q    <= '0;
      lsa_q   <= '0;
      psr_q   <= '0;
      tgt_q   <= '0;
    end else if (accept) begin
      cause_q <= cause_d;
      pc_q    <= bus_io.req_pc;
      lsa_q   <= bus_io.req_lsa;
      psr_q   <= bus_io.msr_psr;
      tgt_q   <= tgt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_FLUSH;
      S_FLUSH:  if (bus_io.flush_ack) state_d = S_COMMIT;
      S_COMMIT: state_d = S_REDIR;
      S_REDIR:  if (bus_io.redir_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Commit writes are pure decodes of COMMIT, so an async reset can never leave one asserted.
  always_comb begin
    bus_io.exp_busy        = (state_q != S_IDLE);
    bus_io.flush_req       = (state_q == S_FLUSH);
    bus_io.msr_exp_ent     = 1'b0;
    bus_io.msr_psr_restore = 1'b0;
    bus_io.msr_epsr_we     = 1'b0;
    bus_io.msr_epc_we      = 1'b0;
    bus_io.msr_elsa_we     = 1'b0;
    bus_io.msr_epsr_nxt    = psr_q;
    bus_io.msr_epc_nxt     = (cause_q == C_SYSCALL) ? pc_q + NCPU_DW'(4) : pc_q;
    bus_io.msr_elsa_nxt    = lsa_q;
    bus_io.redir_valid     = (state_q == S_REDIR);
    bus_io.redir_pc        = tgt_q;
    if (state_q == S_COMMIT) begin
      if (cause_q == C_ERET) begin
        bus_io.msr_psr_restore = 1'b1;
      end else begin
        bus_io.msr_exp_ent = 1'b1;
        bus_io.msr_epsr_we = 1'b1;
        bus_io.msr_epc_we  = 1'b1;
        bus_io.msr_elsa_we = (cause_q == C_DTLB);
      end
    end
  end

endmodule

// File: tb/tb_ncpu32k_exp_seq.sv
// Scoreboard bench for ncpu32k_exp_seq: stimulus queues expected commits and
// redirects, a monitor pops and compares them as the DUT presents them.
module tb_ncpu32k_exp_seq;
  localparam int DW  = 32;
  localparam int PDW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ncpu32k_exp_seq_if #(.DW(DW), .PSR_DW(PDW)) bus();

  ncpu32k_exp_seq #(.NCPU_DW(DW), .NCPU_PSR_DW(PDW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.master)
  );

  typedef struct {
    logic           ent;
    logic           restore;
    logic           epsr_we;
    logic [PDW-1:0] epsr;
    logic           epc_we;
    logic [31:0]    epc;
    logic           elsa_we;
    logic [31:0]    elsa;
    int             cyc;
  } commit_t;

  commit_t     cq[$];
  logic [31:0] rq[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  initial begin
    commit_t     e;
    logic [31:0] hold_pc;
    logic        rv_prev;
    rv_prev = 1'b0;
    hold_pc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rv_prev = 1'b0;
      end else begin
        if (bus.msr_exp_ent || bus.msr_psr_restore || bus.msr_epsr_we ||
            bus.msr_epc_we || bus.msr_elsa_we) begin
          if (cq.size() == 0) begin
            chk("unexpected_commit", 64'd1, 64'd0);
          end else begin
            e = cq.pop_front();
            chk("exp_ent", bus.msr_exp_ent, e.ent);
            chk("psr_restore", bus.msr_psr_restore, e.restore);
            chk("epsr_we", bus.msr_epsr_we, e.epsr_we);
            chk("epc_we", bus.msr_epc_we, e.epc_we);
            chk("elsa_we", bus.msr_elsa_we, e.elsa_we);
            if (e.epsr_we) chk("epsr_nxt", bus.msr_epsr_nxt, e.epsr);
            if (e.epc_we)  chk("epc_nxt", bus.msr_epc_nxt, e.epc);
            if (e.elsa_we) chk("elsa_nxt", bus.msr_elsa_nxt, e.elsa);
            if (e.cyc >= 0) chk("commit_cycle", cyc, e.cyc);
          end
        end
        if (bus.redir_valid) begin
          if (rv_prev) chk("redir_stable", bus.redir_pc, hold_pc);
          hold_pc = bus.redir_pc;
          if (bus.redir_ready) begin
            if (rq.size() == 0) chk("unexpected_redir", 64'd1, 64'd0);
            else chk("redir_pc", bus.redir_pc, rq.pop_front());
          end
        end
        rv_prev = bus.redir_valid && !bus.redir_ready;
      end
    end
  end

  task automatic push_exc(input logic [PDW-1:0] psr, input logic [31:0] epc,
                          input logic elsa_we, input logic [31:0] elsa,
                          input int c, input logic [31:0] rpc);
    commit_t e;
    e.ent = 1'b1; e.restore = 1'b0; e.epsr_we = 1'b1; e.epsr = psr;
    e.epc_we = 1'b1; e.epc = epc; e.elsa_we = elsa_we; e.elsa = elsa; e.cyc = c;
    cq.push_back(e);
    rq.push_back(rpc);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.exp_busy && n < 60);
    if (bus.exp_busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  // reqs = {ifault, dtlb, syscall, eret, irq}
  task automatic drive(input logic [4:0] reqs, input logic [31:0] pc, input logic [31:0] lsa);
    {bus.req_ifault, bus.req_dtlb, bus.req_syscall, bus.req_eret, bus.irq} = reqs;
    bus.req_pc  = pc;
    bus.req_lsa = lsa;
  endtask

  task automatic issue(input logic [4:0] reqs, input logic [31:0] pc, input logic [31:0] lsa);
    @(posedge clk); #1;
    drive(reqs, pc, lsa);
    @(posedge clk); #1;
    drive(5'b0, pc, lsa);
    wait_idle();
  endtask

  initial begin
    commit_t e;
    int n;
    rst = 1'b1;
    drive(5'b0, 32'h0, 32'h0);
    bus.msr_psr     = 10'h05A;
    bus.msr_psr_ire = 1'b0;
    bus.msr_epc     = 32'h0000_3000;
    bus.flush_ack   = 1'b1;
    bus.redir_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.exp_busy, 0);
    chk("rst_flush_req", bus.flush_req, 0);
    chk("rst_exp_ent", bus.msr_exp_ent, 0);
    chk("rst_restore", bus.msr_psr_restore, 0);
    chk("rst_we", {bus.msr_epsr_we, bus.msr_epc_we, bus.msr_elsa_we}, 0);
    chk("rst_redir_valid", bus.redir_valid, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", bus.exp_busy, 0);

    // syscall: pc+4, vector 0x0C, commit two cycles after acceptance cycle
    @(posedge clk); #1;
    push_exc(10'h05A, 32'h104, 1'b0, 32'h0, cyc + 2, 32'h0000_000C);
    drive(5'b00100, 32'h100, 32'h0);
    @(posedge clk); #1;
    drive(5'b0, 32'h100, 32'h0);
    @(negedge clk);
    chk("flush_req_syscall", bus.flush_req, 1);
    wait_idle();

    // data fault
    bus.msr_psr = 10'h3C1;
    push_exc(10'h3C1, 32'h200, 1'b1, 32'hDEAD_0000, -1, 32'h0000_0008);
    issue(5'b01000, 32'h200, 32'hDEAD_0000);

    // irq masked for 20 cycles, then enabled
    @(posedge clk); #1;
    drive(5'b00001, 32'h300, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("irq_masked_busy", bus.exp_busy, 0);
    end
    @(posedge clk); #1;
    push_exc(10'h3C1, 32'h300, 1'b0, 32'h0, cyc + 2, 32'h0000_0010);
    bus.msr_psr_ire = 1'b1;
    @(posedge clk); #1;
    drive(5'b0, 32'h300, 32'h0);
    wait_idle();

    // simultaneous ifault + dtlb + irq: ifault wins, no elsa write
    push_exc(10'h3C1, 32'h400, 1'b0, 32'h0, -1, 32'h0000_0004);
    issue(5'b11001, 32'h400, 32'h5555_AAAA);
    bus.msr_psr_ire = 1'b0;

    // ERET: restore only
    e.ent = 1'b0; e.restore = 1'b1; e.epsr_we = 1'b0; e.epsr = '0;
    e.epc_we = 1'b0; e.epc = '0; e.elsa_we = 1'b0; e.elsa = '0; e.cyc = -1;
    cq.push_back(e);
    rq.push_back(32'h0000_3000);
    issue(5'b00010, 32'h600, 32'h0);

    // 32-bit wrap of syscall return address
    push_exc(10'h3C1, 32'h0000_0000, 1'b0, 32'h0, -1, 32'h0000_000C);
    issue(5'b00100, 32'hFFFF_FFFC, 32'h0);

    // delayed flush_ack and redir_ready; ERET pulse while busy must be ignored
    bus.flush_ack   = 1'b0;
    bus.redir_ready = 1'b0;
    push_exc(10'h3C1, 32'h500, 1'b1, 32'h1234_5678, -1, 32'h0000_0008);
    @(posedge clk); #1;
    drive(5'b01000, 32'h500, 32'h1234_5678);
    @(posedge clk); #1;
    drive(5'b00010, 32'h500, 32'h1234_5678);
    repeat (2) @(posedge clk);
    #1;
    drive(5'b0, 32'h500, 32'h1234_5678);
    @(negedge clk);
    chk("flush_req_hold", bus.flush_req, 1);
    @(posedge clk); #1;
    bus.flush_ack = 1'b1;
    if (cq.size() == 1) cq[0].cyc = cyc + 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.redir_valid && n < 20);
    chk("redir_valid_seen", bus.redir_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    bus.redir_ready = 1'b1;
    wait_idle();

    // reset during FLUSH: no writes ever, outputs drop at once
    bus.flush_ack = 1'b0;
    @(posedge clk); #1;
    drive(5'b00100, 32'h700, 32'h0);
    @(posedge clk); #1;
    drive(5'b0, 32'h700, 32'h0);
    @(negedge clk);
    chk("pre_rst_busy", bus.exp_busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", bus.exp_busy, 0);
    chk("midrst_flush_req", bus.flush_req, 0);
    chk("midrst_writes", {bus.msr_exp_ent, bus.msr_psr_restore, bus.msr_epsr_we,
                          bus.msr_epc_we, bus.msr_elsa_we, bus.redir_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.flush_ack = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", bus.exp_busy, 0);

    chk("commit_queue_empty", cq.size(), 0);
    chk("redir_queue_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
